ysyx_22040931_lsu: RTL

- Multi-cycle load/store unit directly downstream of the EX stage; replaces the combinational DPI memory path.
- Accepts one memory request per transaction and drives a valid/ready data bus with an 8-byte-aligned address, byte mask and lane-shifted store data.
- Returns sign- or zero-extended load data plus rd to the MEM/WB path.
- Holds `busy` high so the pipeline stalls while a transaction is outstanding.

---
 rtl/ysyx_22040931_lsu.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ysyx_22040931_lsu.sv
// Multi-cycle load/store unit: one request at a time over a valid/ready bus.
// Optional misaligned-access check enabled by YSYX_22040931_LSU_MISALIGN_CHK_EN.
module ysyx_22040931_lsu #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              busy,
  output logic              resp_valid,
  output logic              resp_wr,
  output logic [4:0]        resp_rd,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wmask,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t             state_reg, state_next;
  logic               wr_reg;
  logic [1:0]         size_reg;
  logic               uns_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [4:0]         rd_reg;
  logic [DATA_W-1:0]  rdata_reg;
  logic               misalign;
  logic               accept;
  logic [5:0]         shamt;
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  load_data;
  logic [7:0]         lane_mask;

  assign accept = (state_reg == IDLE) && req_valid;
  assign shamt  = {addr_reg[2:0], 3'b000};

`ifdef YSYX_22040931_LSU_MISALIGN_CHK_EN
  logic err_reg;

  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      2'd3:    misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       err_reg <= 1'b0;
    else if (accept) err_reg <= misalign;
  end

  assign resp_err = err_reg;
`else
  assign misalign = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) state_next = misalign ? RESP : REQ;
      REQ:  if (bus_ready) state_next = wr_reg ? RESP : WAIT;
      WAIT: if (bus_rvalid) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_reg    <= 1'b0;
      size_reg  <= 2'd0;
      uns_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_reg    <= 5'd0;
      rdata_reg <= '0;
    end else if (accept) begin
      wr_reg    <= req_wr;
      size_reg  <= req_size;
      uns_reg   <= req_unsigned;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
      rd_reg    <= req_rd;
      rdata_reg <= '0;
    end else if (state_reg == WAIT && bus_rvalid) begin
      rdata_reg <= load_data;
    end
  end

  // Load path: shift the addressed lane down, then extend to full width.
  always_comb begin
    shifted   = bus_rdata >> shamt;
    load_data = shifted;
    case (size_reg)
      2'd0: load_data = uns_reg ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      2'd1: load_data = uns_reg ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      2'd2: load_data = uns_reg ? {{(DATA_W-32){1'b0}}, shifted[31:0]}
                                : {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  // Lanes shifted beyond byte 7 fall off the 8-bit mask.
  always_comb begin
    lane_mask = 8'h00;
    case (size_reg)
      2'd0:    lane_mask = 8'h01 << addr_reg[2:0];
      2'd1:    lane_mask = 8'h03 << addr_reg[2:0];
      2'd2:    lane_mask = 8'h0F << addr_reg[2:0];
      default: lane_mask = 8'hFF;
    endcase
  end

  assign req_ready  = (state_reg == IDLE) && !reset;
  assign busy       = (state_reg != IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_wr    = wr_reg;
  assign resp_rd    = rd_reg;
  assign resp_rdata = rdata_reg;
  assign bus_valid  = (state_reg == REQ);
  assign bus_wr     = (state_reg == REQ) && wr_reg;
  assign bus_addr   = {addr_reg[ADDR_W-1:3], 3'b000};
  assign bus_wmask  = wr_reg ? lane_mask : 8'h00;
  assign bus_wdata  = wr_reg ? (wdata_reg << shamt) : '0;

endmodule
